// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and request type for the register-file writeback arbiter.
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requests, hazard queries and register-file write port of the arbiter.
interface regfile_wb_arbiter_if;

    logic                             a_valid;
    logic [regfile_pkg::AW-1:0]       a_rd;
    logic [regfile_pkg::XLEN-1:0]     a_data;
    logic                             a_ready;
    logic                             b_valid;
    logic [regfile_pkg::AW-1:0]       b_rd;
    logic [regfile_pkg::XLEN-1:0]     b_data;
    logic                             b_ready;
    logic                             issue_valid;
    logic [regfile_pkg::AW-1:0]       issue_rd;
    logic [regfile_pkg::AW-1:0]       rs1_addr;
    logic [regfile_pkg::AW-1:0]       rs2_addr;
    logic                             rs1_busy;
    logic                             rs2_busy;
    logic                             wr_rd_en;
    logic [regfile_pkg::AW-1:0]       addr_wr;
    logic [regfile_pkg::XLEN-1:0]     write_port;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  a_ready, b_ready, rs1_busy, rs2_busy,
               wr_rd_en, addr_wr, write_port
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               issue_valid, issue_rd, rs1_addr, rs2_addr,
        output a_ready, b_ready, rs1_busy, rs2_busy,
               wr_rd_en, addr_wr, write_port
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register with two
// combinational hazard query ports.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_rd,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_rd,
    input  logic [AW-1:0] i_rs1_addr,
    input  logic [AW-1:0] i_rs2_addr,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy
);

    logic [NREGS-1:0] r_busy;

    // The set is applied after the clear so a younger issue to the register
    // being retired this cycle keeps it busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_clr_en)
                r_busy[i_clr_rd] <= 1'b0;
            if (i_set_en && (i_set_rd != '0))
                r_busy[i_set_rd] <= 1'b1;
        end
    end

    assign o_rs1_busy = !rst && (i_rs1_addr != '0) && r_busy[i_rs1_addr];
    assign o_rs2_busy = !rst && (i_rs2_addr != '0) && r_busy[i_rs2_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A)
// and load unit (B), with a registered write stage and pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic    r_rr_b;
    logic    r_wr_en;
    wb_req_t r_out;
    logic    w_gnt_a;
    logic    w_gnt_b;
    wb_req_t w_win;

    // r_rr_b low means A wins a tie; whichever side is granted hands priority over.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst) begin
            if (bus.a_valid && (!bus.b_valid || !r_rr_b))
                w_gnt_a = 1'b1;
            else if (bus.b_valid)
                w_gnt_b = 1'b1;
        end
    end

    always_comb begin
        w_win.rd   = bus.b_rd;
        w_win.data = bus.b_data;
        if (w_gnt_a) begin
            w_win.rd   = bus.a_rd;
            w_win.data = bus.a_data;
        end
    end

    // Writes to x0 are accepted and loaded but never raise the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_b  <= 1'b0;
            r_wr_en <= 1'b0;
            r_out   <= '0;
        end else begin
            if (w_gnt_a)
                r_rr_b <= 1'b1;
            else if (w_gnt_b)
                r_rr_b <= 1'b0;
            r_wr_en <= (w_gnt_a || w_gnt_b) && (w_win.rd != '0);
            if (w_gnt_a || w_gnt_b)
                r_out <= w_win;
        end
    end

    assign bus.a_ready    = w_gnt_a;
    assign bus.b_ready    = w_gnt_b;
    assign bus.wr_rd_en   = r_wr_en;
    assign bus.addr_wr    = r_out.rd;
    assign bus.write_port = r_out.data;

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (bus.issue_valid),
        .i_set_rd   (bus.issue_rd),
        .i_clr_en   (r_wr_en),
        .i_clr_rd   (r_out.rd),
        .i_rs1_addr (bus.rs1_addr),
        .i_rs2_addr (bus.rs2_addr),
        .o_rs1_busy (bus.rs1_busy),
        .o_rs2_busy (bus.rs2_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic             m_prefer_b;
    logic             m_wen;
    logic [AW-1:0]    m_addr;
    logic [XLEN-1:0]  m_data;
    logic [NREGS-1:0] m_busy;

    function automatic logic exp_ra();
        if (rst || !bus.a_valid) return 1'b0;
        if (!bus.b_valid) return 1'b1;
        return !m_prefer_b;
    endfunction

    function automatic logic exp_rb();
        if (rst || !bus.b_valid) return 1'b0;
        if (!bus.a_valid) return 1'b1;
        return m_prefer_b;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] r);
        if (rst || r == '0) return 1'b0;
        return m_busy[r];
    endfunction

    task automatic tick();
        logic ga, gb;
        ga = exp_ra();
        gb = exp_rb();
        @(posedge clk);
        if (rst) begin
            m_prefer_b = 1'b0;
            m_wen      = 1'b0;
            m_addr     = '0;
            m_data     = '0;
            m_busy     = '0;
        end else begin
            if (m_wen) m_busy[m_addr] = 1'b0;
            if (bus.issue_valid && bus.issue_rd != '0) m_busy[bus.issue_rd] = 1'b1;
            if (ga) begin
                m_prefer_b = 1'b1;
                m_wen = (bus.a_rd != '0); m_addr = bus.a_rd; m_data = bus.a_data;
            end else if (gb) begin
                m_prefer_b = 1'b0;
                m_wen = (bus.b_rd != '0); m_addr = bus.b_rd; m_data = bus.b_data;
            end else begin
                m_wen = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.rs1_addr = '0; bus.rs2_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h1111_1111;
        bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'h2222_2222;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
        n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b want 0", bus.b_ready); end
        n_tests++; if (bus.wr_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_rd_en: got %b want 0", bus.wr_rd_en); end
        n_tests++; if (bus.addr_wr !== 5'd0) begin n_fail++; $display("FAIL reset_addr_wr: got %0d want 0", bus.addr_wr); end
        n_tests++; if (bus.write_port !== 32'd0) begin n_fail++; $display("FAIL reset_write_port: got %h want 0", bus.write_port); end
        n_tests++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rs1_busy: got %b want 0", bus.rs1_busy); end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_a();
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %b want 1", bus.a_ready); end
        n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL single_b_ready: got %b want 0", bus.b_ready); end
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en: got %b want 1", bus.wr_rd_en); end
        n_tests++; if (bus.addr_wr !== 5'd5) begin n_fail++; $display("FAIL single_addr: got %0d want 5", bus.addr_wr); end
        n_tests++; if (bus.write_port !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", bus.write_port); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en: got %b want 0", bus.wr_rd_en); end
        n_tests++; if (bus.addr_wr !== 5'd5) begin n_fail++; $display("FAIL idle_addr_hold: got %0d want 5", bus.addr_wr); end
        n_tests++; if (bus.write_port !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idle_data_hold: got %h want deadbeef", bus.write_port); end
    endtask

    task automatic test_alternate();
        logic [AW-1:0] exp_addr [4];
        int na, nb;
        exp_addr[0] = 5'd10; exp_addr[1] = 5'd20; exp_addr[2] = 5'd11; exp_addr[3] = 5'd21;
        na = 0; nb = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.a_valid = 1'b1; bus.a_rd = 5'(10 + na); bus.a_data = 32'hA000_0000 + 32'(na);
            bus.b_valid = 1'b1; bus.b_rd = 5'(20 + nb); bus.b_data = 32'hB000_0000 + 32'(nb);
            @(negedge clk);
            n_tests++; if (bus.a_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL alt_a_ready[%0d]: got %b want %b", i, bus.a_ready, (i % 2 == 0)); end
            n_tests++; if (bus.b_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_b_ready[%0d]: got %b want %b", i, bus.b_ready, (i % 2 == 1)); end
            if (i > 0) begin
                n_tests++; if (bus.wr_rd_en !== 1'b1 || bus.addr_wr !== exp_addr[i-1]) begin
                    n_fail++; $display("FAIL alt_write[%0d]: got en=%b addr=%0d want en=1 addr=%0d", i, bus.wr_rd_en, bus.addr_wr, exp_addr[i-1]);
                end
            end
            if (bus.a_ready === 1'b1) na++;
            if (bus.b_ready === 1'b1) nb++;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b1 || bus.addr_wr !== exp_addr[3]) begin
            n_fail++; $display("FAIL alt_write[4]: got en=%b addr=%0d want en=1 addr=%0d", bus.wr_rd_en, bus.addr_wr, exp_addr[3]);
        end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
        tick();
        bus.issue_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h0000_1234;
        bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd0;
        @(negedge clk);
        n_tests++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL x0_b_ready: got %b want 1", bus.b_ready); end
        tick();
        bus.b_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %b want 0", bus.wr_rd_en); end
        n_tests++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL x0_busy_kept: got %b want 1", bus.rs1_busy); end
        n_tests++; if (bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy_x0: got %b want 0", bus.rs2_busy); end
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0; bus.rs1_addr = 5'd7;
        @(negedge clk);
        n_tests++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b want 1", bus.rs1_busy); end
        bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'h0000_0777;
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b1 || bus.addr_wr !== 5'd7) begin n_fail++; $display("FAIL sb_write7: got en=%b addr=%0d want en=1 addr=7", bus.wr_rd_en, bus.addr_wr); end
        n_tests++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_during_write: got %b want 1", bus.rs1_busy); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_clear: got %b want 0", bus.rs1_busy); end
        // Issue to 7 again, then reissue 7 during the cycle its write lands
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'h0000_0778;
        tick();
        bus.a_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b1 || bus.addr_wr !== 5'd7) begin n_fail++; $display("FAIL sb_write7b: got en=%b addr=%0d want en=1 addr=7", bus.wr_rd_en, bus.addr_wr); end
        tick();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b want 1", bus.rs1_busy); end
        // Issue to x0 never marks anything busy
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        tick();
        bus.issue_valid = 1'b0; bus.rs2_addr = 5'd0;
        @(negedge clk);
        n_tests++; if (bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL sb_x0: got %b want 0", bus.rs2_busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'hCAFE_F00D;
        tick();
        bus.a_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wr_en: got %b want 1", bus.wr_rd_en); end
        tick();
        rst = 1'b0;
        bus.rs1_addr = 5'd9;
        bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h1;
        bus.b_valid = 1'b1; bus.b_rd = 5'd2; bus.b_data = 32'h2;
        @(negedge clk);
        n_tests++; if (bus.wr_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %b want 0", bus.wr_rd_en); end
        n_tests++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.rs1_busy); end
        n_tests++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rr: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic ha, hb;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!bus.a_valid) begin
                bus.a_valid = 1'($urandom); bus.a_rd = 5'($urandom); bus.a_data = $urandom;
            end
            if (!bus.b_valid) begin
                bus.b_valid = 1'($urandom); bus.b_rd = 5'($urandom); bus.b_data = $urandom;
            end
            bus.issue_valid = 1'($urandom);
            bus.issue_rd = 5'($urandom);
            bus.rs1_addr = 5'($urandom);
            bus.rs2_addr = 5'($urandom);
            @(negedge clk);
            n_tests++; if (bus.a_ready !== exp_ra() || bus.b_ready !== exp_rb()) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got a=%b b=%b want a=%b b=%b", i, bus.a_ready, bus.b_ready, exp_ra(), exp_rb());
            end
            n_tests++; if (bus.wr_rd_en !== m_wen || bus.addr_wr !== m_addr || bus.write_port !== m_data) begin
                n_fail++; $display("FAIL rnd_write[%0d]: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", i, bus.wr_rd_en, bus.addr_wr, bus.write_port, m_wen, m_addr, m_data);
            end
            n_tests++; if (bus.rs1_busy !== exp_busy(bus.rs1_addr) || bus.rs2_busy !== exp_busy(bus.rs2_addr)) begin
                n_fail++; $display("FAIL rnd_busy[%0d]: got rs1=%b rs2=%b want rs1=%b rs2=%b", i, bus.rs1_busy, bus.rs2_busy, exp_busy(bus.rs1_addr), exp_busy(bus.rs2_addr));
            end
            ha = exp_ra();
            hb = exp_rb();
            tick();
            if (ha) bus.a_valid = 1'b0;
            if (hb) bus.b_valid = 1'b0;
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        m_prefer_b = 1'b0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
        idle_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_single_a();
        test_alternate();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: port A (ALU/branch results) and port B (load unit).
- Round-robin arbitration when both requesters are valid.
- One registered output stage that drives the register file's write enable, address and data.
- A 32-entry pending-write scoreboard, so issue logic can stall on RAW hazards against unwritten destinations.
- Sits between the execute/memory stages and the register file in the multi-cycle/pipelined core.

Parameters:
XLEN, 32, data width of the write port
NREGS, 32, number of architectural registers; also the scoreboard depth
AW, 5, register address width, equal to $clog2(NREGS)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
a_valid  in  1  ALU writeback request
a_rd  in  AW  ALU destination register
a_data  in  XLEN  ALU result
a_ready  out  1  ALU request accepted this cycle
b_valid  in  1  load writeback request
b_rd  in  AW  load destination register
b_data  in  XLEN  load result
b_ready  out  1  load request accepted this cycle
issue_valid  in  1  an instruction with a destination is issuing
issue_rd  in  AW  destination of the issuing instruction
rs1_addr  in  AW  source-1 hazard query
rs2_addr  in  AW  source-2 hazard query
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
wr_rd_en  out  1  register file write enable
addr_wr  out  AW  register file write address
write_port  out  XLEN  register file write data

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high.
  - On reset, wr_rd_en=0, addr_wr=0, write_port=0, the rr pointer points at A, and all scoreboard bits are clear.
  - a_ready, b_ready, rs1_busy and rs2_busy are 0 during reset.
- Arbitration (combinational ready, registered output):
  - Only A valid: a_ready=1. Only B valid: b_ready=1.
  - Both valid: the port the rr pointer points at is granted.
  - On any grant the pointer moves to the other port.
  - At most one ready is high per cycle.
  - A handshake is valid&&ready.
- Latency: the winning request is captured into the output register on the handshake edge. wr_rd_en is high in the next cycle, and the register file writes at the end of that cycle.
  - Throughput is one write per cycle.
  - No handshake in a cycle means wr_rd_en=0 next cycle; addr_wr and write_port hold their previous values.
- Writes to x0:
  - Accepted normally, so ready is asserted.
  - The output register is loaded with wr_rd_en=0.
  - The scoreboard is not touched.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - The edge on which wr_rd_en=1 clears busy[addr_wr].
  - If set and clear target the same register in the same cycle, set wins, because the issuing instruction is younger.
  - rsN_busy = busy[rsN_addr] combinationally; it is always 0 for address 0.
  - busy stays set through the cycle in which the register file is being written, so a reader never sees stale data.
- Requesters must hold valid, rd and data stable until ready. The arbiter does not check this.
- Reset mid-operation: in-flight output writes are dropped (wr_rd_en=0 next cycle) and the scoreboard is cleared. The pipeline is flushed alongside.
- Multiple outstanding writes to the same rd are not tracked. Issue logic must stall on rd busy (WAW) before issuing.

Decomposition:
- Package regfile_pkg: XLEN, NREGS, AW constants; typedef wb_req_t {rd, data}.
- Sub-module wb_scoreboard contains the busy-bit array, set/clear priority and the two query ports. The arbiter and output register stay in the top module.

Test Plan:
- Reset, then A: a_valid=1, a_rd=5, a_data=0xDEADBEEF. Required: a_ready=1 the same cycle; next cycle wr_rd_en=1, addr_wr=5, write_port=0xDEADBEEF.
- A and B both valid for 4 cycles, distinct rd. Required: grants alternate A,B,A,B; exactly one ready per cycle; wr_rd_en high on 4 consecutive cycles.
- b_valid with b_rd=0, data 0x1234. Required: b_ready=1, then wr_rd_en=0 the next cycle; busy unchanged.
- issue_rd=7, then rs1_addr=7. Required: rs1_busy=1 until the edge where wr_rd_en=1 with addr_wr=7, then 0. Also check issue_rd=7 and a write to 7 in the same cycle: busy remains 1.
- rs2_addr=0 after issue_rd=0. Required: rs2_busy=0.
- rst asserted in the cycle after a handshake. Required: wr_rd_en=0 the next cycle; all busy bits are 0; the rr pointer is back on A.
